// File: rtl/bmf_pkg.sv
// Shared types and helpers for the Boolean-matrix-factorization decoder.
//   bmf_state_e  : decoder FSM states (unconfigured / running)
//   DefaultH     : rank-3 adder basis, row i at index i, bit 0 = out0
//   clog2_min1() : $clog2 clamped to at least 1 (row index width)
package bmf_pkg;

  typedef enum logic [0:0] {
    StUncfg = 1'b0,
    StRun   = 1'b1
  } bmf_state_e;

  localparam int unsigned DefK = 3;
  localparam int unsigned DefM = 4;

  localparam logic [DefK-1:0][DefM-1:0] DefaultH = {4'b1000, 4'b0100, 4'b0011};

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bmf_decoder_if.sv
// Stream bundle for bmf_decoder: basis-row config stream, latent input stream and
// decoded output stream.
//   master : the environment (drives cfg/lat, consumes out)
//   slave  : the decoder
interface bmf_decoder_if #(
  parameter int unsigned K = 3,
  parameter int unsigned M = 4
);
  import bmf_pkg::*;

  localparam int unsigned RowW = clog2_min1(K);

  logic            cfg_valid;
  logic            cfg_ready;
  logic [RowW-1:0] cfg_row;
  logic [M-1:0]    cfg_data;

  logic            lat_valid;
  logic            lat_ready;
  logic [K-1:0]    lat_data;

  logic            out_valid;
  logic            out_ready;
  logic [M-1:0]    out_data;

  modport master (
    output cfg_valid, cfg_row, cfg_data, lat_valid, lat_data, out_ready,
    input  cfg_ready, lat_ready, out_valid, out_data
  );

  modport slave (
    input  cfg_valid, cfg_row, cfg_data, lat_valid, lat_data, out_ready,
    output cfg_ready, lat_ready, out_valid, out_data
  );

endinterface

// File: rtl/bmf_or_product.sv
// Combinational Boolean (OR-of-ANDs) vector-matrix product.
//   lat_i  : K-bit latent vector
//   h_i    : K x M basis, h_i[i] is row i
//   prod_o : prod_o[j] = OR_i (lat_i[i] & h_i[i][j])
module bmf_or_product #(
  parameter int unsigned K = 3,
  parameter int unsigned M = 4
) (
  input  logic [K-1:0]        lat_i,
  input  logic [K-1:0][M-1:0] h_i,
  output logic [M-1:0]        prod_o
);

  always_comb begin
    prod_o = '0;
    for (int i = 0; i < K; i++) begin
      if (lat_i[i]) begin
        prod_o = prod_o | h_i[i];
      end
    end
  end

endmodule

// File: rtl/bmf_decoder.sv
// Streaming BMF decoder: out = lat (x) H over the OR/AND semiring, with a
// runtime-loadable basis H.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : cfg / lat / out valid-ready streams (slave side)
//   loaded_o  : every basis row has been written since reset
//   cfg_err_o : sticky, a write addressed a row >= K
//   count_o   : delivered output words, saturating
module bmf_decoder
  import bmf_pkg::*;
#(
  parameter int unsigned K  = 3,
  parameter int unsigned M  = 4,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  bmf_decoder_if.slave  bus,
  output logic          loaded_o,
  output logic          cfg_err_o,
  output logic [CW-1:0] count_o
);

  localparam int unsigned RowW = clog2_min1(K);

  bmf_state_e          state_q, state_d;
  logic [K-1:0][M-1:0] h_q, h_d;
  logic [K-1:0]        mask_q, mask_d;
  logic                out_valid_q, out_valid_d;
  logic [M-1:0]        out_data_q, out_data_d;
  logic [CW-1:0]       count_q, count_d;
  logic                cfg_err_q, cfg_err_d;

  logic                cfg_fire, lat_fire, out_fire;
  logic [K-1:0]        row_hit;
  logic [M-1:0]        prod;

  // Config writes only land while no output word is held, so a rewrite can never
  // change the basis under an in-flight word.
  assign bus.cfg_ready = ~out_valid_q;
  assign cfg_fire      = bus.cfg_valid & bus.cfg_ready;

  // Config has priority: a pending write blocks the latent stream.
  assign bus.lat_ready = (state_q == StRun) & ~bus.cfg_valid & (~out_valid_q | bus.out_ready);
  assign lat_fire      = bus.lat_valid & bus.lat_ready;
  assign out_fire      = out_valid_q & bus.out_ready;

  // One-hot row decode; an out-of-range index matches nothing.
  always_comb begin
    row_hit = '0;
    for (int i = 0; i < K; i++) begin
      row_hit[i] = cfg_fire & (bus.cfg_row == RowW'(i));
    end
  end

  bmf_or_product #(
    .K (K),
    .M (M)
  ) u_or_product (
    .lat_i  (bus.lat_data),
    .h_i    (h_q),
    .prod_o (prod)
  );

  // Basis, row mask and error flag.
  always_comb begin
    h_d       = h_q;
    mask_d    = mask_q | row_hit;
    cfg_err_d = cfg_err_q | (cfg_fire & ~(|row_hit));
    for (int i = 0; i < K; i++) begin
      if (row_hit[i]) begin
        h_d[i] = bus.cfg_data;
      end
    end
  end

  // FSM next state: leave UNCFG once the mask (including this cycle's write) is full.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StUncfg: if (&mask_d) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StUncfg;
    endcase
  end

  // Output register and delivered-word counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    if (lat_fire) begin
      out_valid_d = 1'b1;
      out_data_d  = prod;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (out_fire && (count_q != {CW{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StUncfg;
      h_q         <= '0;
      mask_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      mask_q      <= mask_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign loaded_o      = (state_q == StRun);
  assign cfg_err_o     = cfg_err_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_bmf_decoder.sv
// Scoreboard bench for bmf_decoder (K=3, M=4). A second instance with CW=3 mirrors
// the same input stimulus to observe counter saturation.
module tb_bmf_decoder;
  import bmf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        loaded, cfg_err, loaded_s, cfg_err_s;
  logic [15:0] count;
  logic [2:0]  count_s;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bmf_decoder_if #(.K(3), .M(4)) bus ();
  bmf_decoder_if #(.K(3), .M(4)) bus_s ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bmf_decoder #(.K(3), .M(4), .CW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .loaded_o  (loaded),
    .cfg_err_o (cfg_err),
    .count_o   (count)
  );

  assign bus_s.cfg_valid = bus.cfg_valid;
  assign bus_s.cfg_row   = bus.cfg_row;
  assign bus_s.cfg_data  = bus.cfg_data;
  assign bus_s.lat_valid = bus.lat_valid;
  assign bus_s.lat_data  = bus.lat_data;
  assign bus_s.out_ready = bus.out_ready;

  bmf_decoder #(.K(3), .M(4), .CW(3)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_s),
    .loaded_o  (loaded_s),
    .cfg_err_o (cfg_err_s),
    .count_o   (count_s)
  );

  // Reference model state
  logic [3:0] h_m [3];
  logic       err_m;
  int         cnt_m = 0;
  logic [3:0] exp_q [$];

  logic rnd_en    = 1'b0;
  logic rdy_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] ref_dec(input logic [2:0] l);
    logic [3:0] r = 4'b0000;
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 3; i++)
        if (l[i] && h_m[i][j]) r[j] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) h_m[i] = 4'b0000;
    err_m = 1'b0;
  endtask

  // Single driver of out_ready: random in the random phase, else rdy_force.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rnd_en ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Monitor: pops expected word on every output handshake and tracks the counter.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      cnt_m = 0;
    end else begin
      chk("count", 32'(count), 32'(cnt_m));
      chk("count_sat", 32'(count_s), 32'((cnt_m > 7) ? 7 : cnt_m));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_data), 32'hdead);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          chk("out_data", 32'(bus.out_data), 32'(e));
          chk("out_data_sat", 32'(bus_s.out_data), 32'(e));
        end
        cnt_m++;
      end
    end
  end

  task automatic cfg_write(input logic [1:0] row, input logic [3:0] data);
    bit ok = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_row   = row;
    bus.cfg_data  = data;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (loaded) chk("cfg_prio_lat_ready", 32'(bus.lat_ready), 0);
      if (bus.cfg_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("cfg_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (ok) begin
      if (row < 3) h_m[row] = data;
      else err_m = 1'b1;
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic send_lat(input logic [2:0] d);
    bit ok = 0;
    bus.lat_valid = 1'b1;
    bus.lat_data  = d;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.lat_ready) begin
        ok = 1;
        break;
      end
    end
    if (ok) exp_q.push_back(ref_dec(d));
    else chk("lat_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.lat_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic load_default();
    for (int i = 0; i < 3; i++) begin
      chk("loaded_before_last", 32'(loaded), 0);
      cfg_write(2'(i), DefaultH[i]);
    end
    chk("loaded_after_last", 32'(loaded), 1);
  endtask

  initial begin
    int t0;
    bus.cfg_valid = 1'b0;
    bus.cfg_row   = '0;
    bus.cfg_data  = '0;
    bus.lat_valid = 1'b0;
    bus.lat_data  = '0;
    do_reset();

    // Reset values
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_cfg_ready", 32'(bus.cfg_ready), 1);
    chk("rst_lat_ready", 32'(bus.lat_ready), 0);
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);

    // Unconfigured: latent words are refused
    @(posedge clk); #1;
    bus.lat_valid = 1'b1;
    bus.lat_data  = 3'b111;
    repeat (4) begin
      @(negedge clk);
      chk("uncfg_lat_ready", 32'(bus.lat_ready), 0);
      chk("uncfg_out_valid", 32'(bus.out_valid), 0);
    end
    @(posedge clk); #1;
    bus.lat_valid = 1'b0;

    load_default();

    // Back-to-back stream 0..7, one word per cycle
    t0 = cyc;
    for (int v = 0; v < 8; v++) send_lat(3'(v));
    chk("stream_cycles", 32'(cyc - t0), 8);
    drain();
    chk("count_after_stream", 32'(count), 8);
    chk("count_sat_after_stream", 32'(count_s), 7);

    // Backpressure
    rdy_force = 1'b0;
    send_lat(3'b101);
    bus.lat_valid = 1'b1;
    bus.lat_data  = 3'b110;
    repeat (3) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_data", 32'(bus.out_data), 32'b1011);
      chk("bp_lat_ready", 32'(bus.lat_ready), 0);
    end
    @(posedge clk); #1;
    rdy_force = 1'b1;
    @(negedge clk);
    chk("bp_release_accept", 32'(bus.lat_ready), 1);
    exp_q.push_back(ref_dec(3'b110));
    @(posedge clk); #1;
    bus.lat_valid = 1'b0;
    drain();

    // Out-of-range row, then rewrite row 0
    cfg_write(2'd3, 4'b1111);
    chk("cfg_err_set", 32'(cfg_err), 1);
    chk("cfg_err_loaded", 32'(loaded), 1);
    cfg_write(2'd0, 4'b0001);
    send_lat(3'b001);
    drain();

    // Randomized mix of words, rewrites and backpressure
    rnd_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        cfg_write(2'($urandom_range(0, 3)), 4'($urandom));
        chk("rnd_cfg_err", 32'(cfg_err), 32'(err_m));
        chk("rnd_loaded", 32'(loaded), 1);
      end else begin
        send_lat(3'($urandom));
      end
    end
    rnd_en = 1'b0;
    drain();

    // Reset while a word is held and count == 5
    do_reset();
    chk("rst2_loaded", 32'(loaded), 0);
    chk("rst2_cfg_err", 32'(cfg_err), 0);
    load_default();
    for (int v = 1; v <= 5; v++) send_lat(3'(v));
    drain();
    chk("pre_rst_count", 32'(count), 5);
    rdy_force = 1'b0;
    send_lat(3'b011);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 1);
    bus.lat_valid = 1'b1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_loaded", 32'(loaded), 0);
    chk("midrst_lat_ready", 32'(bus.lat_ready), 0);
    chk("midrst_out_data", 32'(bus.out_data), 0);
    bus.lat_valid = 1'b0;
    rdy_force = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
